// File: rtl/filter2d_pkg.sv
// Types shared by the 2D filter window generator and the filter core.
package filter2d_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int unsigned DEF_DIN_WIDTH = 8;
  localparam int unsigned DEF_WIN_SIZE  = 3;

  // window[i][j]: i = row (0 = oldest line), j = column (0 = leftmost).
  typedef logic [DEF_WIN_SIZE-1:0][DEF_WIN_SIZE-1:0][DEF_DIN_WIDTH-1:0] window_t;

endpackage

// File: rtl/functions_pkg.sv
// Shared elaboration-time helper functions.
package functions_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/filter2d_line_buf.sv
// One-line pixel delay: simple dual-port RAM, read-first, 1-cycle read latency.
module filter2d_line_buf
  import functions_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 640,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr_i];
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/filter2d_window_gen.sv
// Raster-scan sliding-window generator: line buffers plus a WIN_SIZE x WIN_SIZE
// shift register, emitting only windows fully inside the current frame.
module filter2d_window_gen
  import functions_pkg::*;
  import filter2d_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = 8,
  parameter int unsigned WIN_SIZE   = 3,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              pix_vld,
  input  logic                                              pix_sof,
  input  logic [DIN_WIDTH-1:0]                              pix,
  output logic                                              win_vld,
  output logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DIN_WIDTH-1:0]  window,
  output logic                                              frame_done
);

  localparam int unsigned CW = clog2(IMG_WIDTH);
  localparam int unsigned RW = clog2(IMG_HEIGHT);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          restart, acc, last_col, last_pix, vld_pos;
  logic          win_vld_q, frame_done_q;
  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][DIN_WIDTH-1:0] win_q;
  logic [DIN_WIDTH-1:0] new_col [WIN_SIZE];

  // Position of the pixel on the bus; a start-of-frame pixel is always (0,0).
  always_comb begin
    restart  = pix_vld && pix_sof;
    acc      = pix_vld && (pix_sof || (state_q != IDLE));
    cur_col  = restart ? '0 : col_q;
    cur_row  = restart ? '0 : row_q;
    last_col = (cur_col == CW'(IMG_WIDTH - 1));
    last_pix = last_col && (cur_row == RW'(IMG_HEIGHT - 1));
    vld_pos  = (cur_row >= RW'(WIN_SIZE - 1)) && (cur_col >= CW'(WIN_SIZE - 1));

    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (acc) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_pix ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      if (restart) begin
        state_d = FILL;
      end else if (last_pix) begin
        state_d = IDLE;
      end else if ((state_q == FILL) && (cur_row == RW'(WIN_SIZE - 1)) && (cur_col == '0)) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_vld_q    <= acc && vld_pos;
      frame_done_q <= acc && last_pix;
    end
  end

  // Line buffers read one column ahead (col_d) so data is ready when the pixel lands.
  assign new_col[WIN_SIZE-1] = pix;

  for (genvar k = 0; k < WIN_SIZE - 1; k++) begin : g_lb
    filter2d_line_buf #(
      .WIDTH (DIN_WIDTH),
      .DEPTH (IMG_WIDTH)
    ) u_line_buf (
      .clk       (clk),
      .wr_en_i   (acc),
      .wr_addr_i (cur_col),
      .wr_data_i (new_col[k+1]),
      .rd_addr_i (col_d),
      .rd_data_o (new_col[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q <= '0;
    end else if (acc) begin
      for (int i = 0; i < WIN_SIZE; i++) begin
        for (int j = 0; j < WIN_SIZE - 1; j++) begin
          win_q[i][j] <= win_q[i][j+1];
        end
        win_q[i][WIN_SIZE-1] <= new_col[i];
      end
    end
  end

  assign win_vld    = win_vld_q;
  assign window     = win_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_filter2d_window_gen.sv
// Randomized self-checking bench for filter2d_window_gen on an 8x6 image, 3x3 window.
module tb_filter2d_window_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned WS = 3;
  localparam int unsigned IW = 8;
  localparam int unsigned IH = 6;

  logic clk = 1'b0;
  logic reset;
  logic pix_vld;
  logic pix_sof;
  logic [DW-1:0] pix;
  logic win_vld;
  logic frame_done;
  logic [WS-1:0][WS-1:0][DW-1:0] window;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the frame as received, plus the raster position.
  logic [DW-1:0] img [IH][IW];
  int   m_row, m_col;
  bit   m_active;
  logic exp_vld, exp_done;
  bit   win_known;
  logic [WS-1:0][WS-1:0][DW-1:0] exp_win;
  int   pulses, dones;

  filter2d_window_gen #(
    .DIN_WIDTH  (DW),
    .WIN_SIZE   (WS),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_vld    (pix_vld),
    .pix_sof    (pix_sof),
    .pix        (pix),
    .win_vld    (win_vld),
    .window     (window),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pval(input int r, input int c, input logic [DW-1:0] mask);
    return DW'(r * 16 + c) ^ mask;
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_row     = 0;
    m_col     = 0;
    exp_vld   = 1'b0;
    exp_done  = 1'b0;
    exp_win   = '0;
    win_known = 1'b1;
  endtask

  // Drive one cycle, advance the model, sample outputs #1 after the edge.
  task automatic step(input logic v, input logic s, input logic [DW-1:0] p);
    int r, c;
    pix_vld  = v;
    pix_sof  = s;
    pix      = p;
    exp_vld  = 1'b0;
    exp_done = 1'b0;
    if (v && (s || m_active)) begin
      if (s) begin
        m_active = 1'b1;
        m_row    = 0;
        m_col    = 0;
      end
      r = m_row;
      c = m_col;
      img[r][c] = p;
      if (r >= WS - 1 && c >= WS - 1) begin
        exp_vld   = 1'b1;
        win_known = 1'b1;
        for (int i = 0; i < WS; i++)
          for (int j = 0; j < WS; j++)
            exp_win[i][j] = img[r - WS + 1 + i][c - WS + 1 + j];
      end else begin
        win_known = 1'b0;
      end
      if (r == IH - 1 && c == IW - 1) begin
        exp_done = 1'b1;
        m_active = 1'b0;
        m_row    = 0;
        m_col    = 0;
      end else if (c == IW - 1) begin
        m_col = 0;
        m_row = r + 1;
      end else begin
        m_col = c + 1;
      end
    end
    @(posedge clk);
    #1;
    if (win_vld === 1'b1) pulses++;
    if (frame_done === 1'b1) dones++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pix_vld = 1'b0;
    pix_sof = 1'b0;
    pix = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (win_vld !== 1'b0 || frame_done !== 1'b0 || window !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got vld=%b done=%b win=%h want 0 0 0", win_vld, frame_done, window);
    end
    reset = 1'b0;
  endtask

  task automatic test_no_sof();
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, DW'($urandom));
      n_vec++;
      if (win_vld !== exp_vld || frame_done !== exp_done || window !== exp_win) begin
        n_err++;
        $display("FAIL nosof k%0d: got vld=%b done=%b win=%h want %b %b %h", k, win_vld, frame_done, window, exp_vld, exp_done, exp_win);
      end
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL nosof pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_continuous();
    bit seen_first = 1'b0;
    pulses = 0;
    dones  = 0;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        step(1'b1, (r == 0 && c == 0), pval(r, c, 8'h00));
        n_vec++;
        if (win_vld !== exp_vld || frame_done !== exp_done) begin
          n_err++;
          $display("FAIL cont strobes @%0d,%0d: got vld=%b done=%b want %b %b", r, c, win_vld, frame_done, exp_vld, exp_done);
        end
        if (win_known) begin
          n_vec++;
          if (window !== exp_win) begin
            n_err++;
            $display("FAIL cont window @%0d,%0d: got %h want %h", r, c, window, exp_win);
          end
        end
        if (exp_vld && !seen_first) begin
          seen_first = 1'b1;
          n_vec++;
          if (window[0][0] !== 8'h00 || window[0][1] !== 8'h01 || window[0][2] !== 8'h02 ||
              window[2][0] !== 8'h20 || window[2][1] !== 8'h21 || window[2][2] !== 8'h22) begin
            n_err++;
            $display("FAIL cont first window: got %h want rows 000102 / 202122", window);
          end
        end
        if (r == IH - 1 && c == IW - 1) begin
          n_vec++;
          if (window[2][2] !== 8'h57 || frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL cont last window: got [2][2]=%h done=%b want 57 1", window[2][2], frame_done);
          end
        end
      end
    end
    n_vec++;
    if (pulses !== 24 || dones !== 1) begin
      n_err++;
      $display("FAIL cont counts: got pulses=%0d dones=%0d want 24 1", pulses, dones);
    end
  endtask

  task automatic test_gaps();
    pulses = 0;
    dones  = 0;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        while ($urandom_range(0, 2) == 0) begin
          step(1'b0, 1'($urandom), DW'($urandom));
          n_vec++;
          if (win_vld !== 1'b0 || frame_done !== 1'b0 || (win_known && window !== exp_win)) begin
            n_err++;
            $display("FAIL gaps idle @%0d,%0d: got vld=%b done=%b win=%h want 0 0 %h", r, c, win_vld, frame_done, window, exp_win);
          end
        end
        step(1'b1, (r == 0 && c == 0), pval(r, c, 8'h00));
        n_vec++;
        if (win_vld !== exp_vld || frame_done !== exp_done || (win_known && window !== exp_win)) begin
          n_err++;
          $display("FAIL gaps pix @%0d,%0d: got vld=%b done=%b win=%h want %b %b %h", r, c, win_vld, frame_done, window, exp_vld, exp_done, exp_win);
        end
      end
    end
    n_vec++;
    if (pulses !== 24 || dones !== 1) begin
      n_err++;
      $display("FAIL gaps counts: got pulses=%0d dones=%0d want 24 1", pulses, dones);
    end
  endtask

  task automatic test_restart();
    for (int k = 0; k < 3 * IW + 4; k++) begin
      step(1'b1, (k == 0), pval(k / IW, k % IW, 8'h00));
      n_vec++;
      if (win_vld !== exp_vld || frame_done !== exp_done) begin
        n_err++;
        $display("FAIL restart pre k%0d: got vld=%b done=%b want %b %b", k, win_vld, frame_done, exp_vld, exp_done);
      end
    end
    pulses = 0;
    dones  = 0;
    for (int k = 0; k < IW * IH; k++) begin
      step(1'b1, (k == 0), pval(k / IW, k % IW, 8'h80));
      n_vec++;
      if (win_vld !== exp_vld || frame_done !== exp_done || (win_known && window !== exp_win)) begin
        n_err++;
        $display("FAIL restart k%0d: got vld=%b done=%b win=%h want %b %b %h", k, win_vld, frame_done, window, exp_vld, exp_done, exp_win);
      end
      if (k == 2 * IW + 1) begin
        n_vec++;
        if (pulses !== 0) begin
          n_err++;
          $display("FAIL restart fill: got %0d pulses want 0", pulses);
        end
      end
    end
    n_vec++;
    if (pulses !== 24 || dones !== 1) begin
      n_err++;
      $display("FAIL restart counts: got pulses=%0d dones=%0d want 24 1", pulses, dones);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4 * IW + 4; k++) begin
      step(1'b1, (k == 0), pval(k / IW, k % IW, 8'h40));
    end
    reset   = 1'b1;
    pix_vld = 1'b0;
    model_reset();
    #2;
    n_vec++;
    if (win_vld !== 1'b0 || frame_done !== 1'b0 || window !== '0) begin
      n_err++;
      $display("FAIL reset mid: got vld=%b done=%b win=%h want 0 0 0", win_vld, frame_done, window);
    end
    @(posedge clk);
    #1;
    reset  = 1'b0;
    pulses = 0;
    dones  = 0;
    for (int k = 0; k < IW * IH; k++) begin
      step(1'b1, (k == 0), pval(k / IW, k % IW, 8'h00));
      n_vec++;
      if (win_vld !== exp_vld || frame_done !== exp_done || (win_known && window !== exp_win)) begin
        n_err++;
        $display("FAIL reset post k%0d: got vld=%b done=%b win=%h want %b %b %h", k, win_vld, frame_done, window, exp_vld, exp_done, exp_win);
      end
    end
    n_vec++;
    if (pulses !== 24 || dones !== 1) begin
      n_err++;
      $display("FAIL reset post counts: got pulses=%0d dones=%0d want 24 1", pulses, dones);
    end
  endtask

  task automatic test_back_to_back();
    pulses = 0;
    dones  = 0;
    for (int k = 0; k < 2 * IW * IH; k++) begin
      step(1'b1, (k % (IW * IH) == 0), pval((k % (IW * IH)) / IW, k % IW, (k < IW * IH) ? 8'h00 : 8'h80));
      n_vec++;
      if (win_vld !== exp_vld || frame_done !== exp_done || (win_known && window !== exp_win)) begin
        n_err++;
        $display("FAIL b2b k%0d: got vld=%b done=%b win=%h want %b %b %h", k, win_vld, frame_done, window, exp_vld, exp_done, exp_win);
      end
    end
    step(1'b0, 1'b0, '0);
    n_vec++;
    if (pulses !== 48 || dones !== 2) begin
      n_err++;
      $display("FAIL b2b counts: got pulses=%0d dones=%0d want 48 2", pulses, dones);
    end
  endtask

  initial begin
    test_reset();
    test_no_sof();
    test_continuous();
    test_gaps();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/filter2d_window_gen.md
FILTER2D_WINDOW_GEN -- requirements
Module: filter2d_window_gen

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter WIN_SIZE, default 3, window side in pixels (>= 2).
REQ-003 SHALL have parameter IMG_WIDTH, default 640, pixels per line (>= WIN_SIZE).
REQ-004 SHALL have parameter IMG_HEIGHT, default 480, lines per frame (>= WIN_SIZE).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port pix_vld  input  1  pixel qualifier; gaps allowed, no backpressure.
REQ-008 SHALL have port pix_sof  input  1  marks the frame's first pixel (row 0, col 0); sampled only with pix_vld.
REQ-009 SHALL have port pix  input  DIN_WIDTH  raster-order pixel data.
REQ-010 SHALL have port win_vld  output  1  window valid strobe, the same signal filter2d_core takes as win_vld.
REQ-011 SHALL have port window  output  [WIN_SIZE][WIN_SIZE][DIN_WIDTH]  window[i][j], i = row (0 = oldest line), j = column (0 = leftmost).
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when the frame's last pixel is accepted.

Function
REQ-013 SHALL implement states IDLE, FILL, RUN.
REQ-014 SHALL move to FILL from any state on pix_vld && pix_sof, with that pixel taken as row 0, col 0.
REQ-015 SHALL ignore pix_vld without pix_sof in IDLE; no counter, buffer or output change.
REQ-016 SHALL increment col per accepted pixel, wrap IMG_WIDTH-1 -> 0 and then increment row.
REQ-017 SHALL move FILL -> RUN when the pixel at row WIN_SIZE-1, col 0 is accepted.
REQ-018 SHALL return to IDLE and pulse frame_done one cycle after accepting the pixel at row IMG_HEIGHT-1, col IMG_WIDTH-1.
REQ-019 SHALL keep WIN_SIZE-1 line buffers of IMG_WIDTH entries; line k+1 output feeds line k input; read-before-write at address col.
REQ-020 SHALL shift each window row left by one column per accepted pixel: row WIN_SIZE-1 takes pix, row i < WIN_SIZE-1 takes line buffer i output.
REQ-021 SHALL register win_vld exactly 1 cycle after accepting a pixel with row >= WIN_SIZE-1 and col >= WIN_SIZE-1 (valid-only windows, no border padding).
REQ-022 SHALL hold window stable between accepted pixels, with win_vld low otherwise.
REQ-023 SHALL produce exactly (IMG_WIDTH-WIN_SIZE+1)*(IMG_HEIGHT-WIN_SIZE+1) win_vld pulses per complete frame.
REQ-024 SHALL never emit windows that span a line wrap; the col gate in REQ-021 guarantees this.
REQ-025 SHALL treat pix_sof mid-frame as a restart: counters cleared, state FILL, no win_vld until REQ-021 holds again; stale buffer content is never emitted.
REQ-026 SHALL size counters with clog2(IMG_WIDTH) and clog2(IMG_HEIGHT) bits.

Reset
REQ-027 SHALL on reset force state IDLE, row = col = 0, win_vld = 0, frame_done = 0 and window = 0; line buffer contents are don't-care.
REQ-028 SHALL treat reset mid-frame as abandoning the frame, with output resuming only after the next pix_sof.

Structure
REQ-029 SHALL take clog2 from functions_pkg and place the state enum and window typedef in filter2d_pkg.
REQ-030 SHALL implement the line buffer as sub-module filter2d_line_buf (1 read + 1 write per cycle, 1-cycle read latency, RAM-inferable), instantiated WIN_SIZE-1 times.
REQ-031 SHALL drive filter2d_core window/win_vld directly, with identical [i][j] orientation.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, WIN_SIZE=3, pix = row*16+col)
REQ-032 SHALL cover a continuous frame -> 24 win_vld pulses; first window row0 = 00 01 02, row2 = 20 21 22; last window [2][2] = 0x57; frame_done one cycle after pixel 0x57.
REQ-033 SHALL cover the same frame with pix_vld toggled randomly -> identical window sequence and count, window stable across gaps.
REQ-034 SHALL cover pixels without pix_sof after reset -> no win_vld, state IDLE, until a pix_sof pixel arrives.
REQ-035 SHALL cover pix_sof reasserted at row 3, col 4 -> no win_vld for the next 2 lines + 2 pixels, then a correct fresh-frame sequence.
REQ-036 SHALL cover reset asserted at row 4 -> all outputs 0 immediately; a following full frame yields 24 correct windows.
REQ-037 SHALL cover back-to-back frames with the new pix_sof in the cycle after the last pixel -> 48 pulses and 2 frame_done pulses, with no window mixing frames.
